// File: rtl/uart_packet_sched_if.sv
// ==========================================================================
// uart_packet_sched_if : sample handshake and UART transmitter port bundle
// Revision: 1.0
// ==========================================================================
`default_nettype none

interface uart_packet_sched_if #(
  parameter int NUM_WORDS = 6,
  parameter int WORD_BITS = 16
) ();
  logic                           sample_valid;
  logic [NUM_WORDS*WORD_BITS-1:0] sample_in;
  logic                           sample_ready;
  logic                           tx_ready_in;
  logic                           tx_en;
  logic [7:0]                     tx_data;
  logic                           busy;
  logic [7:0]                     drop_cnt;

  modport slave (
    input  sample_valid, sample_in, tx_ready_in,
    output sample_ready, tx_en, tx_data, busy, drop_cnt
  );

  modport master (
    output sample_valid, sample_in, tx_ready_in,
    input  sample_ready, tx_en, tx_data, busy, drop_cnt
  );
endinterface

`default_nettype wire

// File: rtl/uart_packet_sched.sv
// ==========================================================================
// uart_packet_sched : emits SYNC, sample bytes (word 0 first, MSB first), sum
// Revision: 1.0
// ==========================================================================
`default_nettype none

module uart_packet_sched #(
  parameter int         NUM_WORDS = 6,
  parameter int         WORD_BITS = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic                clk_in,
  input logic                n_rst,
  uart_packet_sched_if.slave bus
);

  localparam int                 c_BPW   = WORD_BITS / 8;
  localparam int                 c_N     = NUM_WORDS * c_BPW;
  localparam int                 c_IDX_W = $clog2(c_N + 2);
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(c_N + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                         r_state, w_state_nxt;
  logic [NUM_WORDS*WORD_BITS-1:0] r_sample;
  logic [c_IDX_W-1:0]             r_idx, w_idx_nxt;
  logic [7:0]                     r_csum, w_csum_nxt;
  logic [7:0]                     r_tx_data, w_tx_data_nxt;
  logic                           r_tx_en, w_tx_en_nxt;
  logic                           r_sample_ready, r_busy, w_load;
  logic [7:0]                     r_drop_cnt;
  logic [7:0]                     w_cur_byte;
  logic [7:0]                     w_data_bytes [c_N];

  // Data byte j comes from word j/BPW, most significant byte first
  generate
    for (genvar j = 0; j < c_N; j++) begin : g_byte_map
      assign w_data_bytes[j] =
        r_sample[(j / c_BPW) * WORD_BITS + (c_BPW - 1 - (j % c_BPW)) * 8 +: 8];
    end
  endgenerate

  always_comb begin
    w_cur_byte = SYNC_BYTE;
    for (int j = 0; j < c_N; j++) begin
      if (r_idx == c_IDX_W'(j + 1)) w_cur_byte = w_data_bytes[j];
    end
    if (r_idx == c_LAST) w_cur_byte = r_csum;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_csum_nxt    = r_csum;
    w_tx_en_nxt   = 1'b0;
    w_tx_data_nxt = r_tx_data;
    w_load        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.sample_valid && r_sample_ready) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_csum_nxt  = 8'h00;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.tx_ready_in) begin
          w_tx_en_nxt   = 1'b1;
          w_tx_data_nxt = w_cur_byte;
          if (r_idx != '0 && r_idx != c_LAST) w_csum_nxt = r_csum + w_cur_byte;
          w_state_nxt   = WAIT_ACK;
        end
      end
      // A transmitter that keeps ready high after capture is simply waited out
      WAIT_ACK: begin
        if (!bus.tx_ready_in) w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_ready_in) begin
          if (r_idx == c_LAST) begin
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = ISSUE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= IDLE;
      r_sample       <= '0;
      r_idx          <= '0;
      r_csum         <= 8'h00;
      r_tx_en        <= 1'b0;
      r_tx_data      <= 8'h00;
      r_sample_ready <= 1'b0;
      r_busy         <= 1'b0;
      r_drop_cnt     <= 8'h00;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_csum         <= w_csum_nxt;
      r_tx_en        <= w_tx_en_nxt;
      r_tx_data      <= w_tx_data_nxt;
      r_sample_ready <= (w_state_nxt == IDLE);
      r_busy         <= (w_state_nxt != IDLE);
      if (w_load) r_sample <= bus.sample_in;
      if (bus.sample_valid && !r_sample_ready && r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign bus.sample_ready = r_sample_ready;
  assign bus.tx_en        = r_tx_en;
  assign bus.tx_data      = r_tx_data;
  assign bus.busy         = r_busy;
  assign bus.drop_cnt     = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_packet_sched.sv
// ==========================================================================
// tb_uart_packet_sched : scoreboard bench with a behavioural UART transmitter
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_uart_packet_sched;

  localparam int OVERSAMPLING = 16;

  logic clk_in;
  logic n_rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   pulses   = 0;
  int   ack_hold = 0;
  int   base;
  logic [7:0] sb [$];

  uart_packet_sched_if #(.NUM_WORDS(6), .WORD_BITS(16)) bus ();

  uart_packet_sched #(
    .NUM_WORDS(6),
    .WORD_BITS(16),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk_in(clk_in),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic logic [95:0] pack(input logic [15:0] w0, w1, w2, w3, w4, w5);
    return {w5, w4, w3, w2, w1, w0};
  endfunction

  task automatic push_pkt(input logic [95:0] s, input logic [7:0] exp_sum);
    logic [15:0] w;
    sb.push_back(8'hA5);
    for (int k = 0; k < 6; k++) begin
      w = s[k*16 +: 16];
      sb.push_back(w[15:8]);
      sb.push_back(w[7:0]);
    end
    sb.push_back(exp_sum);
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    @(negedge clk_in);
    while (!bus.sample_ready && k < budget) begin
      @(negedge clk_in);
      k++;
    end
    check("wait_ready", {31'd0, bus.sample_ready}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clk_in);
    while ((bus.busy || sb.size() != 0 || !bus.tx_ready_in) && k < budget) begin
      @(negedge clk_in);
      k++;
    end
    check("wait_idle", {31'd0, (k < budget)}, 32'd1);
  endtask

  task automatic send(input logic [95:0] s, input logic [7:0] cs);
    wait_ready(3000);
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    push_pkt(s, cs);
    @(negedge clk_in);
    bus.sample_valid = 1'b0;
  endtask

  // Transmitter: captures at the edge after tx_en, optionally keeps ready high, then one frame
  initial begin
    bus.tx_ready_in = 1'b1;
    forever begin
      @(negedge clk_in);
      if (bus.tx_en) begin
        @(posedge clk_in);
        repeat (ack_hold) @(posedge clk_in);
        #1 bus.tx_ready_in = 1'b0;
        repeat (10 * OVERSAMPLING) @(posedge clk_in);
        #1 bus.tx_ready_in = 1'b1;
      end
    end
  end

  // Monitor: every tx_en pulse must match the next expected byte and last one cycle
  initial begin
    logic       prev_en;
    logic [7:0] exp_b;
    prev_en = 1'b0;
    forever begin
      @(negedge clk_in);
      if (bus.tx_en) begin
        pulses++;
        check("tx_en_single_cycle", {31'd0, prev_en}, 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL tx_unexpected: got tx_en with byte %0h, required no tx_en", bus.tx_data);
        end else begin
          exp_b = sb.pop_front();
          check("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_b});
        end
      end
      prev_en = bus.tx_en;
    end
  end

  initial begin
    n_rst            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    repeat (3) @(negedge clk_in);
    check("rst_tx_en",        {31'd0, bus.tx_en},        32'd0);
    check("rst_tx_data",      {24'd0, bus.tx_data},      32'd0);
    check("rst_sample_ready", {31'd0, bus.sample_ready}, 32'd0);
    check("rst_busy",         {31'd0, bus.busy},         32'd0);
    check("rst_drop_cnt",     {24'd0, bus.drop_cnt},     32'd0);
    n_rst = 1'b1;
    @(negedge clk_in);
    check("ready_after_reset", {31'd0, bus.sample_ready}, 32'd1);
    base = pulses;
    repeat (50) @(negedge clk_in);
    check("idle_no_tx", pulses - base, 32'd0);

    // Reference packet: checksum 0x4E
    base = pulses;
    send(pack(16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C), 8'h4E);
    wait_idle(4000);
    check("pkt1_pulses", pulses - base, 32'd14);
    check("pkt1_drop_cnt", {24'd0, bus.drop_cnt}, 32'd0);

    // Checksum wrap with three dropped offers mid-packet
    base = pulses;
    send(pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 8'hF4);
    repeat (20) @(negedge clk_in);
    check("busy_in_pkt", {31'd0, bus.busy}, 32'd1);
    bus.sample_in    = pack(16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555);
    bus.sample_valid = 1'b1;
    repeat (3) @(negedge clk_in);
    bus.sample_valid = 1'b0;
    wait_idle(4000);
    check("wrap_pulses", pulses - base, 32'd14);
    check("drop_cnt_3", {24'd0, bus.drop_cnt}, 32'd3);

    // Back-to-back: valid held through packet 1, drop count saturates
    base = pulses;
    wait_ready(3000);
    bus.sample_in    = pack(16'h1122, 16'h3344, 16'h5566, 16'h7788, 16'h99AA, 16'hBBCC);
    bus.sample_valid = 1'b1;
    push_pkt(bus.sample_in, 8'h2E);
    @(negedge clk_in);
    check("b2b_accept", {31'd0, bus.sample_ready}, 32'd0);
    bus.sample_in = pack(16'h8000, 16'h0001, 16'h7FFF, 16'h00FF, 16'h1234, 16'hFEDC);
    push_pkt(bus.sample_in, 8'h1E);
    wait_ready(4000);
    @(negedge clk_in);
    check("b2b_restart_busy",  {31'd0, bus.busy},         32'd1);
    check("b2b_restart_ready", {31'd0, bus.sample_ready}, 32'd0);
    bus.sample_valid = 1'b0;
    wait_idle(4000);
    check("b2b_pulses", pulses - base, 32'd28);
    check("drop_cnt_sat", {24'd0, bus.drop_cnt}, 32'd255);

    // Transmitter slow to drop ready
    ack_hold = 5;
    base = pulses;
    send(pack(16'hDEAD, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h0001), 8'h39);
    wait_idle(5000);
    check("slow_ack_pulses", pulses - base, 32'd14);
    ack_hold = 0;

    // Reset during byte 6, then a fresh packet
    base = pulses;
    send(pack(16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F), 8'hB4);
    for (int k = 0; k < 3000 && (pulses - base) < 6; k++) @(negedge clk_in);
    check("abort_reached_byte6", pulses - base, 32'd6);
    @(negedge clk_in);
    n_rst = 1'b0;
    #1;
    check("abort_tx_en",        {31'd0, bus.tx_en},        32'd0);
    check("abort_tx_data",      {24'd0, bus.tx_data},      32'd0);
    check("abort_sample_ready", {31'd0, bus.sample_ready}, 32'd0);
    check("abort_busy",         {31'd0, bus.busy},         32'd0);
    check("abort_drop_cnt",     {24'd0, bus.drop_cnt},     32'd0);
    sb.delete();
    repeat (2) @(negedge clk_in);
    n_rst = 1'b1;
    base = pulses;
    send(pack(16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5), 8'hBC);
    wait_idle(4000);
    check("fresh_pulses", pulses - base, 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
